// File: rtl/edge_event_pkg.sv
// Shared definitions for the multi-channel edge event monitor: edge-mode
// encodings and the helper that decides whether an edge pulse counts as an event.
package edge_event_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  function automatic logic edge_qualifies(input logic [1:0] mode,
                                          input logic       rise,
                                          input logic       fall);
    logic hit;
    case (mode)
      MODE_OFF:  hit = 1'b0;
      MODE_RISE: hit = rise;
      MODE_FALL: hit = fall;
      MODE_BOTH: hit = rise | fall;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_event_monitor_if.sv
// Bundle of the per-channel input, control and status vectors of the edge event
// monitor; the master side drives inputs/controls, the slave side is the monitor.
interface edge_event_monitor_if #(
  parameter int CHANNELS  = 4,
  parameter int CNT_WIDTH = 8
);

  logic [CHANNELS-1:0]           signal_in;
  logic [2*CHANNELS-1:0]         mode;
  logic [CHANNELS-1:0]           clear;
  logic [CHANNELS-1:0]           level_out;
  logic [CHANNELS-1:0]           rising_edge;
  logic [CHANNELS-1:0]           falling_edge;
  logic [CHANNELS-1:0]           event_pending;
  logic [CHANNELS*CNT_WIDTH-1:0] event_count;

  modport master (
    output signal_in, mode, clear,
    input  level_out, rising_edge, falling_edge, event_pending, event_count
  );

  modport slave (
    input  signal_in, mode, clear,
    output level_out, rising_edge, falling_edge, event_pending, event_count
  );

endinterface

// File: rtl/edge_event_chan.sv
// One monitor channel: synchroniser, glitch filter, edge pulses, sticky pending
// flag and (when EDGE_EVENT_COUNT_EN is defined) a saturating event counter.
module edge_event_chan
  import edge_event_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signal_in,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 level_out,
  output logic                 rising_edge,
  output logic                 falling_edge,
  output logic                 event_pending,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int              FW          = $clog2(FILTER_CYCLES + 1);
  localparam logic [FW-1:0]   FILTER_DONE = FW'(FILTER_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FW-1:0]          filt_cnt;
  logic                   synced;
  logic                   accept;
  logic                   qualified;

  assign synced = sync_q[SYNC_STAGES-1];
  // Once FILTER_CYCLES differing samples have been counted, the toggle is
  // committed on the following edge regardless of the current synced value.
  assign accept    = (filt_cnt == FILTER_DONE);
  assign qualified = edge_qualifies(mode, accept & ~level_out, accept & level_out);

  // NOTE: all state here uses non-blocking assignments so every flop samples
  // pre-edge values; blocking assignments would collapse the sync chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q        <= '0;
      filt_cnt      <= '0;
      level_out     <= 1'b0;
      rising_edge   <= 1'b0;
      falling_edge  <= 1'b0;
      event_pending <= 1'b0;
    end else begin
      sync_q       <= {sync_q[SYNC_STAGES-2:0], signal_in};
      rising_edge  <= accept & ~level_out;
      falling_edge <= accept & level_out;
      if (accept) begin
        level_out <= ~level_out;
        filt_cnt  <= '0;
      end else if (synced != level_out) begin
        filt_cnt <= filt_cnt + FW'(1);
      end else begin
        filt_cnt <= '0;
      end
      event_pending <= qualified | (event_pending & ~clear);
    end
  end

`ifdef EDGE_EVENT_COUNT_EN
  logic [CNT_WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= CNT_WIDTH'(qualified);
    end else if (qualified && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
    end
  end

  assign event_count = cnt_q;
`else
  assign event_count = '0;
`endif

endmodule

// File: rtl/edge_event_monitor.sv
// Multi-channel edge event monitor top: CHANNELS independent edge_event_chan
// instances. Event counters exist only when EDGE_EVENT_COUNT_EN is defined.
module edge_event_monitor #(
  parameter int CHANNELS      = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  edge_event_monitor_if.slave  bus
);

  logic [CHANNELS-1:0]           level_v;
  logic [CHANNELS-1:0]           rise_v;
  logic [CHANNELS-1:0]           fall_v;
  logic [CHANNELS-1:0]           pend_v;
  logic [CHANNELS*CNT_WIDTH-1:0] count_v;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    edge_event_chan #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .signal_in    (bus.signal_in[i]),
      .mode         (bus.mode[2*i +: 2]),
      .clear        (bus.clear[i]),
      .level_out    (level_v[i]),
      .rising_edge  (rise_v[i]),
      .falling_edge (fall_v[i]),
      .event_pending(pend_v[i]),
      .event_count  (count_v[i*CNT_WIDTH +: CNT_WIDTH])
    );
  end

  assign bus.level_out     = level_v;
  assign bus.rising_edge   = rise_v;
  assign bus.falling_edge  = fall_v;
  assign bus.event_pending = pend_v;
  assign bus.event_count   = count_v;

endmodule

// File: tb/tb_edge_event_monitor.sv
// Scoreboard bench for edge_event_monitor: a sample-history reference model
// predicts every cycle's outputs; a separate monitor compares them.
module tb_edge_event_monitor;
  import edge_event_pkg::*;

  localparam int CH   = 4;
  localparam int SS   = 2;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int MAXE = 4096;
  localparam int CMAX = (1 << CW) - 1;

  typedef struct {
    logic [CH-1:0]    level;
    logic [CH-1:0]    rise;
    logic [CH-1:0]    fall;
    logic [CH-1:0]    pend;
    logic [CH*CW-1:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  edge_event_monitor_if #(.CHANNELS(CH), .CNT_WIDTH(CW)) bus ();

  edge_event_monitor #(
    .CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(FC), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   mon_edge = 0;

  logic [CH-1:0]   sig_v   = '0;
  logic [CH-1:0]   clear_v = '0;
  logic [2*CH-1:0] mode_v  = '0;
  logic            rst_v   = 1'b1;

  // Reference model: full history of sampled inputs per channel.
  bit hist [CH][MAXE];
  int n_edge = 0;
  int last_t [CH];
  bit m_level [CH];
  bit m_pend [CH];
  int m_cnt [CH];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s at edge %0d: got %h, expected %h", name, mon_edge, act, req);
  endtask

  // A channel's level flips at edge n when the FC samples feeding the filter
  // at edges n-FC..n-1 all disagreed with the level and no reset/flip occurred
  // inside that window.
  task automatic model_edge();
    exp_t e;
    int   n;
    n = n_edge;
    for (int c = 0; c < CH; c++) begin
      bit r, f, tog, q;
      logic [1:0] md;
      r = 0; f = 0;
      if (rst_v) begin
        m_level[c] = 0; m_pend[c] = 0; m_cnt[c] = 0; last_t[c] = n;
        for (int k = n - SS + 1; k <= n; k++) if (k >= 0) hist[c][k] = 0;
      end else begin
        hist[c][n] = sig_v[c];
        tog = 0;
        if (n - FC - SS >= 0 && last_t[c] < n - FC) begin
          tog = 1;
          for (int j = n - FC; j < n; j++)
            if (hist[c][j - SS] == m_level[c]) tog = 0;
        end
        if (tog) begin
          r = !m_level[c];
          f = m_level[c];
          m_level[c] = !m_level[c];
          last_t[c] = n;
        end
        md = mode_v[2*c +: 2];
        q = (r && md[0]) || (f && md[1]);
        if (clear_v[c]) begin
          m_pend[c] = q;
          m_cnt[c]  = q ? 1 : 0;
        end else begin
          m_pend[c] = m_pend[c] | q;
          if (q && m_cnt[c] < CMAX) m_cnt[c]++;
        end
      end
      e.level[c] = m_level[c];
      e.rise[c]  = r;
      e.fall[c]  = f;
      e.pend[c]  = m_pend[c];
`ifdef EDGE_EVENT_COUNT_EN
      e.cnt[c*CW +: CW] = CW'(m_cnt[c]);
`else
      e.cnt[c*CW +: CW] = '0;
`endif
    end
    exp_q.push_back(e);
    n_edge++;
  endtask

  task automatic step(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.signal_in = sig_v;
      bus.mode      = mode_v;
      bus.clear     = clear_v;
      rst           = rst_v;
      if (n_edge < MAXE - 1) model_edge();
    end
  endtask

  // Monitor: one expected record per active edge, compared 1 time unit later.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("level_out",     64'(bus.level_out),     64'(e.level));
        check("rising_edge",   64'(bus.rising_edge),   64'(e.rise));
        check("falling_edge",  64'(bus.falling_edge),  64'(e.fall));
        check("event_pending", 64'(bus.event_pending), 64'(e.pend));
        check("event_count",   64'(bus.event_count),   64'(e.cnt));
        mon_edge++;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int hold [CH];
    bus.signal_in = '0;
    bus.mode      = '0;
    bus.clear     = '0;

    // Reset with inputs low.
    rst_v = 1'b1; step(3); rst_v = 1'b0;

    // Channel 0: rise-qualified, long pulse.
    mode_v[1:0] = MODE_RISE;
    sig_v[0] = 1'b1; step(10);
    sig_v[0] = 1'b0; step(10);

    // Channel 1: 2-cycle glitch rejected, 3-cycle pulse accepted.
    sig_v[1] = 1'b1; step(2);
    sig_v[1] = 1'b0; step(8);
    sig_v[1] = 1'b1; step(3);
    sig_v[1] = 1'b0; step(10);

    // Channel 2: fall-qualified, both pulses appear.
    mode_v[5:4] = MODE_FALL;
    sig_v[2] = 1'b1; step(8);
    sig_v[2] = 1'b0; step(16);

    // Channel 3: both edges qualified, counter saturates.
    mode_v[7:6] = MODE_BOTH;
    for (int t = 0; t < 20; t++) begin
      sig_v[3] = ~sig_v[3];
      step(6);
    end
    step(8);

    // Clear alone, then clear coinciding with a qualified rising edge.
    clear_v[0] = 1'b1; step(1); clear_v = '0; step(2);
    sig_v[0] = 1'b1; step(SS + FC);
    clear_v[0] = 1'b1; step(1); clear_v = '0; step(4);

    // Mid-run reset with channel 0 held high.
    step(3);
    rst_v = 1'b1; step(2); rst_v = 1'b0;
    step(10);

    // Randomised phase.
    for (int c = 0; c < CH; c++) hold[c] = $urandom_range(1, 8);
    for (int t = 0; t < 800; t++) begin
      for (int c = 0; c < CH; c++) begin
        if (hold[c] == 0) begin
          sig_v[c] = ~sig_v[c];
          hold[c]  = $urandom_range(1, 8);
        end
        hold[c]--;
        clear_v[c] = ($urandom_range(0, 9) == 0);
      end
      if ($urandom_range(0, 19) == 0) mode_v = (2*CH)'($urandom);
      rst_v = ($urandom_range(0, 299) == 0);
      step(1);
    end
    rst_v = 1'b0; clear_v = '0;
    step(2);

    @(posedge clk);
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
